johnson_decoder: RTL and testbench

Receive-side companion to the 4-stage Johnson ring counter. Samples a Johnson code word each valid cycle and decodes it to its binary state index. Checks that every code is legal and is the exact successor (or a repeat) of the previous one, and reports lock status. Sits at the far end of any link carrying a Johnson-coded count, for position recovery and integrity monitoring.

---
 rtl/johnson_decoder.sv | 122 ++++++++++++
 tb/tb_johnson_decoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/johnson_decoder.sv
// rtl/johnson_decoder.sv - Johnson code word decoder with successor checking, lock FSM and error counter.
module johnson_decoder #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8,
  localparam int IDX_W     = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] code_in,
  input  logic             err_clr,
  output logic             out_valid,
  output logic [IDX_W-1:0] index,
  output logic             illegal,
  output logic             seq_err,
  output logic             wrap,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam int M    = 2 * WIDTH;
  localparam int GC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(M - 1);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  state_t           state;
  logic [IDX_W-1:0] ref_idx;
  logic [GC_W-1:0]  gcnt;

  logic             legal;
  logic [IDX_W-1:0] dec_idx;
  logic [IDX_W-1:0] succ_idx;
  logic [GC_W-1:0]  gcnt_inc;
  logic             is_succ;
  logic             is_rep;
  logic             bad_seq;
  logic             err_inc;

  // Each index k < WIDTH has one MSB-filled pattern; the LSB-filled patterns cover the upper half.
  always_comb begin
    legal   = 1'b0;
    dec_idx = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (code_in == ~(ALL_ONES >> k)) begin
        legal   = 1'b1;
        dec_idx = IDX_W'(k);
      end
      if (code_in == (ALL_ONES >> (WIDTH - 1 - k))) begin
        legal   = 1'b1;
        dec_idx = IDX_W'(M - 1 - k);
      end
    end
  end

  assign succ_idx = (ref_idx == LAST_IDX) ? '0 : ref_idx + 1'b1;
  assign gcnt_inc = gcnt + 1'b1;
  assign is_succ  = legal && (state != IDLE) && (dec_idx == succ_idx);
  assign is_rep   = legal && (state != IDLE) && (dec_idx == ref_idx);
  assign bad_seq  = legal && (state != IDLE) && !is_succ && !is_rep;
  assign err_inc  = in_valid && (!legal || bad_seq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ref_idx   <= '0;
      gcnt      <= '0;
      out_valid <= 1'b0;
      index     <= '0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      wrap      <= 1'b0;
      locked    <= 1'b0;
      err_count <= '0;
    end else begin
      out_valid <= in_valid;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      wrap      <= 1'b0;
      if (in_valid) begin
        index   <= legal ? dec_idx : '0;
        illegal <= !legal;
        if (!legal) begin
          state  <= IDLE;
          gcnt   <= '0;
          locked <= 1'b0;
        end else if (state == IDLE) begin
          ref_idx <= dec_idx;
          gcnt    <= '0;
          state   <= TRACK;
          locked  <= 1'b0;
        end else if (is_succ) begin
          ref_idx <= dec_idx;
          wrap    <= (ref_idx == LAST_IDX);
          // gcnt stays at LOCK_COUNT once locked, so only TRACK advances it
          if (state == TRACK) begin
            gcnt <= gcnt_inc;
            if (gcnt_inc == GC_W'(LOCK_COUNT)) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
        end else if (bad_seq) begin
          seq_err <= 1'b1;
          ref_idx <= dec_idx;
          gcnt    <= '0;
          state   <= TRACK;
          locked  <= 1'b0;
        end
      end
      if (err_clr) begin
        err_count <= '0;
      end else if (err_inc && (err_count != ERR_MAX)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_johnson_decoder.sv
// tb/tb_johnson_decoder.sv - Self-checking bench for johnson_decoder against a ring-counter reference model.
module tb_johnson_decoder;

  localparam int M  = 8;
  localparam int LC = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] code_in;
  logic       err_clr;
  logic       out_valid;
  logic [2:0] index;
  logic       illegal;
  logic       seq_err;
  logic       wrap;
  logic       locked;
  logic [7:0] err_count;

  johnson_decoder #(.WIDTH(4), .LOCK_COUNT(LC), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .code_in(code_in), .err_clr(err_clr),
    .out_valid(out_valid), .index(index), .illegal(illegal), .seq_err(seq_err),
    .wrap(wrap), .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Legal codes are generated by stepping a 4-stage Johnson counter from 0000.
  logic [3:0] codes [M];

  bit m_ref_valid, m_locked;
  int m_ref, m_g, m_cnt;
  bit e_ov, e_ill, e_seq, e_wrap;
  int e_idx;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [3:0] c);
    for (int i = 0; i < M; i++) if (codes[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_ref_valid = 0; m_locked = 0; m_ref = 0; m_g = 0; m_cnt = 0;
    e_ov = 0; e_ill = 0; e_seq = 0; e_wrap = 0; e_idx = 0;
  endtask

  task automatic model_step(input bit v, input logic [3:0] c, input bit clr);
    int i;
    bit err;
    err = 0;
    e_ov = v; e_ill = 0; e_seq = 0; e_wrap = 0;
    if (v) begin
      i = decode(c);
      if (i < 0) begin
        e_ill = 1; e_idx = 0; err = 1;
        m_ref_valid = 0; m_g = 0; m_locked = 0;
      end else begin
        e_idx = i;
        if (!m_ref_valid) begin
          m_ref_valid = 1; m_ref = i; m_g = 0;
        end else if (i == (m_ref + 1) % M) begin
          e_wrap = (m_ref == M - 1);
          m_ref = i;
          if (!m_locked) begin
            m_g++;
            if (m_g >= LC) m_locked = 1;
          end
        end else if (i != m_ref) begin
          e_seq = 1; err = 1;
          m_ref = i; m_g = 0; m_locked = 0;
        end
      end
    end
    if (clr) m_cnt = 0;
    else if (err && m_cnt < 255) m_cnt++;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_valid", out_valid, e_ov);
      chk("index", index, e_idx);
      chk("illegal", illegal, e_ill);
      chk("seq_err", seq_err, e_seq);
      chk("wrap", wrap, e_wrap);
      chk("locked", locked, m_locked);
      chk("err_count", err_count, m_cnt);
    end
  end

  task automatic drive(input bit v, input logic [3:0] c, input bit clr);
    in_valid = v; code_in = c; err_clr = clr;
    @(posedge clk);
    model_step(v, c, clr);
    #1;
    in_valid = 0; err_clr = 0;
  endtask

  task automatic feed(input logic [3:0] c);
    drive(1'b1, c, 1'b0);
  endtask

  initial begin
    logic [3:0] c;
    int r;
    codes[0] = 4'b0000;
    for (int i = 1; i < M; i++) codes[i] = {~codes[i-1][0], codes[i-1][3:1]};

    rst = 1; in_valid = 0; code_in = 0; err_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err_count", err_count, 0);
    rst = 0;
    cmp_en = 1;

    feed(4'b1000); chk("lit_idx_1000", index, 1);
    feed(4'b1100); chk("lit_idx_1100", index, 2);
    feed(4'b1110); chk("lit_locked_early", locked, 0);
    feed(4'b1111); chk("lit_idx_1111", index, 4);
    chk("lit_locked_4th", locked, 1);
    chk("lit_err_0", err_count, 0);

    feed(4'b0111); feed(4'b0011); feed(4'b0001);
    chk("lit_idx_0001", index, 7);
    feed(4'b0000);
    chk("lit_wrap", wrap, 1); chk("lit_wrap_idx", index, 0); chk("lit_wrap_locked", locked, 1);
    feed(4'b1000); chk("lit_wrap_once", wrap, 0);
    feed(4'b1100);
    feed(4'b1111);
    chk("lit_skip_seq", seq_err, 1); chk("lit_skip_locked", locked, 0); chk("lit_skip_err", err_count, 1);
    feed(4'b0111); feed(4'b0011); chk("lit_relock_pre", locked, 0);
    feed(4'b0001); chk("lit_relock", locked, 1);

    feed(4'b0101);
    chk("lit_ill", illegal, 1); chk("lit_ill_idx", index, 0); chk("lit_ill_locked", locked, 0);
    feed(4'b0011); chk("lit_idle_noseq", seq_err, 0);
    feed(4'b0001); feed(4'b0000); chk("lit_idle_wrap", wrap, 1);
    feed(4'b1000); chk("lit_idle_relock", locked, 1); chk("lit_err_2", err_count, 2);

    feed(4'b1100); feed(4'b1110);
    for (int i = 0; i < 5; i++) begin
      feed(4'b1110);
      chk("lit_rep_seq", seq_err, 0); chk("lit_rep_locked", locked, 1); chk("lit_rep_ov", out_valid, 1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b0101, 1'b0);
      chk("lit_idle_ov", out_valid, 0); chk("lit_idle_ill", illegal, 0); chk("lit_idle_hold", index, 3);
    end

    for (int i = 0; i < 300; i++) feed((i % 2) ? 4'b1001 : 4'b0101);
    chk("lit_sat", err_count, 255);
    drive(1'b1, 4'b0100, 1'b1);
    chk("lit_clr_wins", err_count, 0); chk("lit_clr_ill", illegal, 1);

    feed(4'b0011); feed(4'b0001); feed(4'b0000); feed(4'b1000);
    chk("lit_pre_rst_locked", locked, 1);
    #2 rst = 1;
    model_reset();
    #1;
    chk("lit_arst_locked", locked, 0); chk("lit_arst_ov", out_valid, 0);
    chk("lit_arst_idx", index, 0); chk("lit_arst_err", err_count, 0);
    @(posedge clk); #1 rst = 0;
    feed(4'b1100);
    chk("lit_post_rst_idx", index, 2); chk("lit_post_rst_seq", seq_err, 0);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      c = codes[(m_ref + 1) % M];
      else if (r < 70) c = codes[m_ref % M];
      else if (r < 80) c = codes[$urandom_range(0, M - 1)];
      else             c = 4'($urandom_range(0, 15));
      drive((r < 93), c, ($urandom_range(0, 49) == 0));
    end

    @(negedge clk);
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
